// File: rtl/ar_fifo_unpack_if.sv
// FIFO-style dequeue port: the producer holds EMPTY_N/D and the consumer pulses DEQ.
// The master modport is the side that presents data; the slave modport is the side that drains it.
interface ar_fifo_unpack_if #(
    parameter int width = 32
);
    logic             EMPTY_N;
    logic [width-1:0] D;
    logic             DEQ;

    modport master (output EMPTY_N, output D, input  DEQ);
    modport slave  (input  EMPTY_N, input  D, output DEQ);
endinterface

// File: rtl/ar_fifo_unpack.sv
// Width-down converter: drains wide words from an upstream FIFO port and replays them
// as ratio narrow lanes, lane 0 first, at one lane per clock with no inter-word bubble.
//
// full | meaning
// -----+------------------------------------------------------------
//  0   | nothing held; fetch whenever upstream is non-empty
//  1   | hold[owidth-1:0] is the current lane, lane = its index
module ar_fifo_unpack #(
    parameter int iwidth  = 128,
    parameter int l2ratio = 2,
    parameter int owidth  = iwidth >> l2ratio
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                CLR,
    ar_fifo_unpack_if.slave     up,
    ar_fifo_unpack_if.master    dn,
    output logic                LAST
);
    localparam int ratio = 1 << l2ratio;
    localparam logic [l2ratio-1:0] lane_last = l2ratio'(ratio - 1);

    logic [iwidth-1:0]  hold;
    logic [l2ratio-1:0] lane;
    logic               full;

    logic clear;
    logic cons;
    logic at_last;
    logic fetch;

    assign clear   = RST || CLR;
    assign cons    = full && dn.DEQ;
    assign at_last = (lane == lane_last);
    // A reset/clear cycle must not pop upstream, or that word would be lost.
    assign fetch   = !clear && up.EMPTY_N && (!full || (cons && at_last));

    always_ff @(posedge CLK) begin
        if (clear) begin
            full <= 1'b0;
            lane <= '0;
            hold <= '0;
        end else if (fetch) begin
            hold <= up.D;
            lane <= '0;
            full <= 1'b1;
        end else if (cons && at_last) begin
            full <= 1'b0;
            lane <= '0;
        end else if (cons) begin
            hold <= hold >> owidth;
            lane <= lane + 1'b1;
        end
    end

    assign up.DEQ     = fetch;
    assign dn.EMPTY_N = full;
    assign dn.D       = hold[owidth-1:0];
    assign LAST       = full && at_last;
endmodule

// File: tb/tb_ar_fifo_unpack.sv
// Bench for ar_fifo_unpack at 32->8 bits: directed scenarios then random traffic,
// checked every cycle against a queue-based model of words and lanes.
module tb_ar_fifo_unpack;
    localparam int IW = 32;
    localparam int L2 = 2;
    localparam int OW = 8;
    localparam int R  = 4;

    logic CLK = 1'b0;
    logic RST;
    logic CLR;
    logic LAST;

    ar_fifo_unpack_if #(.width(IW)) up ();
    ar_fifo_unpack_if #(.width(OW)) dn ();

    ar_fifo_unpack #(.iwidth(IW), .l2ratio(L2), .owidth(OW)) dut (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (CLR),
        .up   (up),
        .dn   (dn),
        .LAST (LAST)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int ideq_cnt = 0;

    logic [OW-1:0] lane_q[$];
    logic [IW-1:0] src_q[$];
    logic [OW-1:0] idle_d;
    bit            gap;

    task automatic chk(input string tag, input logic [IW-1:0] got, input logic [IW-1:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, compare against the model, then advance the model at the edge.
    task automatic step(input logic r, input logic c, input logic dq);
        logic          en;
        logic          exp_ideq;
        logic [IW-1:0] d;
        logic [OW-1:0] exp_d;
        en = !gap && (src_q.size() > 0);
        if (en) d = src_q[0];
        else    d = IW'($urandom);
        RST = r; CLR = c; up.EMPTY_N = en; up.D = d; dn.DEQ = dq;
        exp_ideq = !r && !c && en && (lane_q.size() == 0 || (dq && lane_q.size() == 1));
        if (lane_q.size() != 0) exp_d = lane_q[0];
        else                    exp_d = idle_d;
        #3;
        chk("i_deq",   IW'(up.DEQ),     IW'(exp_ideq));
        chk("empty_n", IW'(dn.EMPTY_N), IW'(lane_q.size() != 0));
        chk("last",    IW'(LAST),       IW'(lane_q.size() == 1));
        chk("d_out",   IW'(dn.D),       IW'(exp_d));
        if (up.DEQ === 1'b1) ideq_cnt++;
        @(posedge CLK);
        if (r || c) begin
            lane_q.delete();
            idle_d = '0;
        end else begin
            if (dq && lane_q.size() != 0) idle_d = lane_q.pop_front();
            if (exp_ideq) begin
                void'(src_q.pop_front());
                lane_q.delete();
                for (int k = 0; k < R; k++) lane_q.push_back(d[k*OW +: OW]);
            end
        end
        #1;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((lane_q.size() != 0 || (!gap && src_q.size() != 0)) && n < budget) begin
            step(1'b0, 1'b0, 1'b1);
            n++;
        end
        chk("drain_budget", IW'(n < budget), IW'(1));
    endtask

    initial begin
        logic [OW-1:0] exp8[8];
        int            c0;
        gap = 1'b0;
        idle_d = '0;
        RST = 1'b1; CLR = 1'b0; up.EMPTY_N = 1'b1; up.D = '0; dn.DEQ = 1'b0;
        @(posedge CLK); #1;

        // reset with upstream non-empty: no fetch while RST is high
        src_q.push_back(32'hDEADBEEF);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        src_q.delete();
        step(1'b0, 1'b0, 1'b0);
        chk("rst_empty_n", IW'(dn.EMPTY_N), 0);
        chk("rst_d_out",   IW'(dn.D),       0);
        chk("rst_last",    IW'(LAST),       0);

        // basic unpack
        c0 = ideq_cnt;
        src_q.push_back(32'h44332211);
        step(1'b0, 1'b0, 1'b1);
        exp8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        for (int i = 0; i < 4; i++) begin
            chk("basic_lane", IW'(dn.D), IW'(exp8[i]));
            chk("basic_last", IW'(LAST), IW'(i == 3));
            step(1'b0, 1'b0, 1'b1);
        end
        chk("basic_empty_after", IW'(dn.EMPTY_N), 0);
        chk("basic_ideq_once", IW'(ideq_cnt - c0), 1);

        // back-to-back words, no bubble
        src_q.push_back(32'h44332211);
        src_q.push_back(32'h88776655);
        step(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk("b2b_valid", IW'(dn.EMPTY_N), 1);
            chk("b2b_lane",  IW'(dn.D),       IW'(exp8[i]));
            step(1'b0, 1'b0, 1'b1);
        end
        chk("b2b_empty_after", IW'(dn.EMPTY_N), 0);

        // downstream stall with a word pending upstream
        src_q.push_back(32'h44332211);
        src_q.push_back(32'h88776655);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        c0 = ideq_cnt;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0);
            chk("stall_d_out",   IW'(dn.D),       32'h22);
            chk("stall_empty_n", IW'(dn.EMPTY_N), 1);
        end
        chk("stall_no_ideq", IW'(ideq_cnt - c0), 0);
        drain(20);

        // spurious DEQ while empty, then one word, then an upstream gap
        step(1'b0, 1'b0, 1'b1);
        chk("spur_empty", IW'(dn.EMPTY_N), 0);
        src_q.push_back(32'hCAFEF00D);
        step(1'b0, 1'b0, 1'b0);
        chk("spur_lane0", IW'(dn.D), 32'h0D);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1);
        gap = 1'b1;
        src_q.push_back(32'h12345678);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("gap_empty", IW'(dn.EMPTY_N), 0);
        end
        gap = 1'b0;
        step(1'b0, 1'b0, 1'b1);
        chk("refill_lane0", IW'(dn.D), 32'h78);
        drain(20);

        // CLR mid-word discards remaining lanes
        src_q.push_back(32'h44332211);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        src_q.push_back(32'h0A0B0C0D);
        step(1'b0, 1'b1, 1'b1);
        chk("clr_empty", IW'(dn.EMPTY_N), 0);
        chk("clr_d_out", IW'(dn.D),       0);
        step(1'b0, 1'b0, 1'b1);
        chk("clr_restart_lane0", IW'(dn.D), 32'h0D);
        chk("clr_restart_last",  IW'(LAST), 0);
        drain(20);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            if (src_q.size() < 3 && $urandom_range(0, 3) != 0) src_q.push_back(IW'($urandom));
            gap = ($urandom_range(0, 5) == 0);
            step(1'b0, ($urandom_range(0, 60) == 0), ($urandom_range(0, 3) != 0));
        end
        gap = 1'b0;
        drain(40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
